// File: rtl/mc_pkg.sv
// Shared definitions for the Shenzhen-I/O-style microcontroller cores:
// instruction field positions, opcode/condition/register codes, the
// saturation limits and small arithmetic helpers used by every core.
package mc_pkg;

    localparam int W     = 11;           // data/port width (signed)
    localparam int IW    = 32;           // instruction width
    localparam int DEPTH = 16;           // instruction words per core
    localparam int PCW   = $clog2(DEPTH);
    localparam int SLPW  = W - 1;        // sleep counter holds positive operands only

    localparam int SAT_MAX_INT = 999;
    localparam int SAT_MIN_INT = -999;
    localparam logic signed [W-1:0]   SAT_MAX      = W'(SAT_MAX_INT);
    localparam logic signed [W-1:0]   SAT_MIN      = W'(SAT_MIN_INT);
    localparam logic signed [2*W-1:0] SAT_MAX_WIDE = (2*W)'(SAT_MAX_INT);
    localparam logic signed [2*W-1:0] SAT_MIN_WIDE = (2*W)'(SAT_MIN_INT);

    // Instruction field positions
    localparam int COND_HI  = 31;
    localparam int COND_LO  = 30;
    localparam int OP_HI    = 29;
    localparam int OP_LO    = 26;
    localparam int AIMM_BIT = 25;
    localparam int A_HI     = 24;
    localparam int A_LO     = 14;
    localparam int BIMM_BIT = 13;
    localparam int B_HI     = 12;
    localparam int B_LO     = 2;

    typedef enum logic [1:0] {
        COND_ALWAYS  = 2'b00,
        COND_POS     = 2'b01,
        COND_NEG     = 2'b10,
        COND_ALWAYS2 = 2'b11
    } cond_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_MOV = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_MUL = 4'd4,
        OP_NOT = 4'd5,
        OP_TEQ = 4'd6,
        OP_TGT = 4'd7,
        OP_TLT = 4'd8,
        OP_SLP = 4'd9,
        OP_JMP = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        FLAG_NONE = 2'd0,
        FLAG_POS  = 2'd1,
        FLAG_NEG  = 2'd2
    } flag_e;

    // Register-select codes (field[2:0] of a non-immediate operand)
    localparam logic [2:0] REG_NULL = 3'd0;
    localparam logic [2:0] REG_ACC  = 3'd1;
    localparam logic [2:0] REG_DAT  = 3'd2;
    localparam logic [2:0] REG_P0   = 3'd3;
    localparam logic [2:0] REG_P1   = 3'd4;

    // Value produced by NOT when acc is zero
    localparam logic signed [W-1:0] NOT_TRUE = W'(100);

    // Sign-extend a data word to the double-width arithmetic domain.
    function automatic logic signed [2*W-1:0] sext(input logic signed [W-1:0] x);
        return {{W{x[W-1]}}, x};
    endfunction

    // Clamp a full-width result into the displayable range -999..999.
    function automatic logic signed [W-1:0] sat_clamp(input logic signed [2*W-1:0] v);
        logic signed [W-1:0] r;
        if (v > SAT_MAX_WIDE)
            r = SAT_MAX;
        else if (v < SAT_MIN_WIDE)
            r = SAT_MIN;
        else
            r = $signed(v[W-1:0]);
        return r;
    endfunction

    // Resolve an operand: literal, or a register read (p1 and unused codes read 0).
    function automatic logic signed [W-1:0] read_operand(
        input logic                imm,
        input logic [W-1:0]        field,
        input logic signed [W-1:0] acc,
        input logic signed [W-1:0] dat,
        input logic signed [W-1:0] p0
    );
        logic signed [W-1:0] v;
        v = '0;
        if (imm) begin
            v = $signed(field);
        end else begin
            case (field[2:0])
                REG_ACC: v = acc;
                REG_DAT: v = dat;
                REG_P0:  v = p0;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/mc_core.sv
// One microcontroller: fetches a word per clk, gates it on the condition
// prefix, executes it against acc/dat/flag/p1, and supports SLP, which stalls
// the core until a given number of big-clock pulses have been seen.
module mc_core
    import mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                posedge_big_clk,
    input  logic signed [W-1:0] i_p0,
    output logic signed [W-1:0] o_p1
);

    logic [PCW-1:0]        program_counter;
    logic [IW-1:0]         final_instruction;

    logic signed [W-1:0]   r_acc;
    logic signed [W-1:0]   r_dat;
    logic signed [W-1:0]   r_p1;
    flag_e                 r_flag;
    logic [SLPW-1:0]       r_sleep_cnt;

    logic [IW-1:0]         w_fetched;
    logic                  w_cond_ok;
    logic                  w_sleeping;
    logic [3:0]            w_op;
    logic [W-1:0]          w_a_field;
    logic [W-1:0]          w_b_field;
    logic [1:0]            w_unused_rsvd;
    logic signed [W-1:0]   w_a;
    logic signed [W-1:0]   w_b;
    logic signed [2*W-1:0] w_acc_wide;
    logic signed [2*W-1:0] w_a_wide;

    logic [PCW-1:0]        w_pc_next;
    logic signed [W-1:0]   w_acc_next;
    logic signed [W-1:0]   w_dat_next;
    logic signed [W-1:0]   w_p1_next;
    flag_e                 w_flag_next;
    logic [SLPW-1:0]       w_sleep_next;

    mc_imem instructionMemory (
        .clk     (clk),
        .i_we    (1'b0),
        .i_waddr ('0),
        .i_wdata ('0),
        .i_raddr (program_counter),
        .o_rdata (w_fetched)
    );

    // Condition prefix check; a flag of NONE satisfies neither + nor -.
    always_comb begin
        w_cond_ok = 1'b1;
        case (w_fetched[COND_HI:COND_LO])
            COND_POS: w_cond_ok = (r_flag == FLAG_POS);
            COND_NEG: w_cond_ok = (r_flag == FLAG_NEG);
            default:  w_cond_ok = 1'b1;
        endcase
    end

    // A skipped instruction becomes the all-zero word, which decodes as NOP.
    assign final_instruction = w_cond_ok ? w_fetched : '0;

    assign w_op          = final_instruction[OP_HI:OP_LO];
    assign w_a_field     = final_instruction[A_HI:A_LO];
    assign w_b_field     = final_instruction[B_HI:B_LO];
    assign w_unused_rsvd = final_instruction[1:0];
    assign w_sleeping    = (r_sleep_cnt != '0);

    assign w_a = read_operand(final_instruction[AIMM_BIT], w_a_field, r_acc, r_dat, i_p0);
    assign w_b = read_operand(final_instruction[BIMM_BIT], w_b_field, r_acc, r_dat, i_p0);

    assign w_acc_wide = sext(r_acc);
    assign w_a_wide   = sext(w_a);

    // Next state: count big-clock pulses while asleep, otherwise execute.
    always_comb begin
        w_pc_next    = program_counter + PCW'(1);
        w_acc_next   = r_acc;
        w_dat_next   = r_dat;
        w_p1_next    = r_p1;
        w_flag_next  = r_flag;
        w_sleep_next = r_sleep_cnt;
        if (w_sleeping) begin
            w_pc_next = program_counter;
            if (posedge_big_clk) begin
                w_sleep_next = r_sleep_cnt - SLPW'(1);
                if (r_sleep_cnt == SLPW'(1)) begin
                    w_pc_next = program_counter + PCW'(1);
                end
            end
        end else begin
            case (w_op)
                OP_MOV: begin
                    case (w_b_field[2:0])
                        REG_ACC: w_acc_next = sat_clamp(w_a_wide);
                        REG_DAT: w_dat_next = sat_clamp(w_a_wide);
                        REG_P1:  w_p1_next  = sat_clamp(w_a_wide);
                        default: begin end
                    endcase
                end
                OP_ADD: w_acc_next = sat_clamp(w_acc_wide + w_a_wide);
                OP_SUB: w_acc_next = sat_clamp(w_acc_wide - w_a_wide);
                OP_MUL: w_acc_next = sat_clamp(w_acc_wide * w_a_wide);
                OP_NOT: w_acc_next = (r_acc == '0) ? NOT_TRUE : '0;
                OP_TEQ: w_flag_next = (w_a == w_b) ? FLAG_POS : FLAG_NEG;
                OP_TGT: w_flag_next = (w_a > w_b)  ? FLAG_POS : FLAG_NEG;
                OP_TLT: w_flag_next = (w_a < w_b)  ? FLAG_POS : FLAG_NEG;
                OP_SLP: begin
                    // Only a strictly positive count puts the core to sleep;
                    // a pulse arriving on the issue cycle is not counted.
                    if (!w_a[W-1] && (w_a != '0)) begin
                        w_sleep_next = w_a[SLPW-1:0];
                        w_pc_next    = program_counter;
                    end
                end
                OP_JMP: w_pc_next = w_a[PCW-1:0];
                default: begin end
            endcase
        end
    end

    // Architectural state update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            program_counter <= '0;
            r_acc           <= '0;
            r_dat           <= '0;
            r_p1            <= '0;
            r_flag          <= FLAG_NONE;
            r_sleep_cnt     <= '0;
        end else begin
            program_counter <= w_pc_next;
            r_acc           <= w_acc_next;
            r_dat           <= w_dat_next;
            r_p1            <= w_p1_next;
            r_flag          <= w_flag_next;
            r_sleep_cnt     <= w_sleep_next;
        end
    end

    assign o_p1 = r_p1;

endmodule

// File: rtl/mc_imem.sv
// Per-core instruction store. Contents are normally loaded from outside the
// design (hierarchically); the write port exists for in-system updates and
// is tied off by the core. Reads are combinational so the fetched word is
// available in the same cycle the program counter points at it.
module mc_imem
    import mc_pkg::*;
(
    input  logic           clk,
    input  logic           i_we,
    input  logic [PCW-1:0] i_waddr,
    input  logic [IW-1:0]  i_wdata,
    input  logic [PCW-1:0] i_raddr,
    output logic [IW-1:0]  o_rdata
);

    logic [IW-1:0] memory [0:DEPTH-1];

    // Optional program write; memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            memory[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = memory[i_raddr];

endmodule

// File: rtl/design_x.sv
// Two identical cores in series: dut0 reads the external input on p0 and
// feeds its p1 to dut1's p0; dut1's p1 register is the system output.
module design_x
    import mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                posedge_big_clk,
    input  logic signed [W-1:0] input_signal,
    output logic signed [W-1:0] output_signal
);

    logic signed [W-1:0] w_link;

    mc_core dut0 (
        .clk             (clk),
        .reset           (reset),
        .posedge_big_clk (posedge_big_clk),
        .i_p0            (input_signal),
        .o_p1            (w_link)
    );

    mc_core dut1 (
        .clk             (clk),
        .reset           (reset),
        .posedge_big_clk (posedge_big_clk),
        .i_p0            (w_link),
        .o_p1            (output_signal)
    );

endmodule

// File: tb/tb_design_x.sv
// Directed bench for the two-core system: programs are written straight into
// each core's instruction memory, then outputs and PCs are compared against
// hand-derived values.
module tb_design_x;
    import mc_pkg::*;

    logic               clk;
    logic               reset;
    logic               big;
    logic signed [10:0] in_sig;
    logic signed [10:0] out_sig;

    int n_checks;
    int n_fail;

    design_x dut (
        .clk             (clk),
        .reset           (reset),
        .posedge_big_clk (big),
        .input_signal    (in_sig),
        .output_signal   (out_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [1:0] c, input logic [3:0] op,
                                        input logic ai, input int a,
                                        input logic bi, input int b);
        logic [10:0] af;
        logic [10:0] bf;
        af = 11'(a);
        bf = 11'(b);
        return {c, op, ai, af, bi, bf, 2'b00};
    endfunction

    task automatic wr(input int core, input logic [3:0] addr, input logic [31:0] w);
        if (core == 0) dut.dut0.instructionMemory.memory[addr] = w;
        else           dut.dut1.instructionMemory.memory[addr] = w;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 16; i++) begin
            wr(0, 4'(i), 32'h0);
            wr(1, 4'(i), 32'h0);
        end
    endtask

    task automatic fill_pass(input int core);
        for (int i = 0; i < 16; i++) wr(core, 4'(i), enc(2'b00, OP_MOV, 1'b0, 3, 1'b0, 4));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        big   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // dut0: TEST p0 against lit; +MOV 1,p1; -MOV 2,p1; JMP 3. dut1 passes through.
    task automatic run_cond(input string tag, input logic [3:0] op, input int lit,
                            input int in_val, input int exp_out);
        clear_all();
        fill_pass(1);
        wr(0, 4'd0, enc(2'b00, op, 1'b0, 3, 1'b1, lit));
        wr(0, 4'd1, enc(2'b01, OP_MOV, 1'b1, 1, 1'b0, 4));
        wr(0, 4'd2, enc(2'b10, OP_MOV, 1'b1, 2, 1'b0, 4));
        wr(0, 4'd3, enc(2'b00, OP_JMP, 1'b1, 3, 1'b0, 0));
        in_sig = 11'(in_val);
        do_reset();
        if (exp_out == 1) begin
            step(2);
            check({tag, "_skip_pc"}, int'(dut.dut0.program_counter), 2);
            check({tag, "_skip_fi"}, int'(dut.dut0.final_instruction), 0);
            step(2);
        end else begin
            step(1);
            check({tag, "_skip_pc"}, int'(dut.dut0.program_counter), 1);
            check({tag, "_skip_fi"}, int'(dut.dut0.final_instruction), 0);
            step(3);
        end
        check({tag, "_out"}, int'(out_sig), exp_out);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        big      = 1'b0;
        in_sig   = '0;

        // Reset state; a +conditional with flag NONE must be gated off
        clear_all();
        wr(0, 4'd0, enc(2'b01, OP_MOV, 1'b1, 5, 1'b0, 4));
        do_reset();
        check("rst_out", int'(out_sig), 0);
        check("rst_pc0", int'(dut.dut0.program_counter), 0);
        check("rst_pc1", int'(dut.dut1.program_counter), 0);
        check("rst_fi_none", int'(dut.dut0.final_instruction), 0);
        step(2);
        check("none_out", int'(out_sig), 0);

        // Passthrough with two-clk latency and input clamping
        clear_all();
        fill_pass(0);
        fill_pass(1);
        in_sig = 11'sd37;
        do_reset();
        step(1);
        check("pass_lat1", int'(out_sig), 0);
        step(1);
        check("pass_37", int'(out_sig), 37);
        in_sig = -11'sd5;
        step(1);
        check("pass_hold", int'(out_sig), 37);
        step(1);
        check("pass_m5", int'(out_sig), -5);
        in_sig = -11'sd1000;
        step(2);
        check("pass_clamp_lo", int'(out_sig), -999);
        in_sig = 11'sd1023;
        step(2);
        check("pass_clamp_hi", int'(out_sig), 999);

        // Saturation high: MOV 900,acc; ADD 500; MOV acc,p1; JMP 3
        clear_all();
        wr(1, 4'd0, enc(2'b00, OP_MOV, 1'b1, 900, 1'b0, 1));
        wr(1, 4'd1, enc(2'b00, OP_ADD, 1'b1, 500, 1'b0, 0));
        wr(1, 4'd2, enc(2'b00, OP_MOV, 1'b0, 1, 1'b0, 4));
        wr(1, 4'd3, enc(2'b00, OP_JMP, 1'b1, 3, 1'b0, 0));
        do_reset();
        step(3);
        check("sat_hi", int'(out_sig), 999);
        step(2);
        check("jmp_self_pc", int'(dut.dut1.program_counter), 3);

        // Saturation low: 900 - 1000 - 1000 clamps at -999
        clear_all();
        wr(1, 4'd0, enc(2'b00, OP_MOV, 1'b1, 900, 1'b0, 1));
        wr(1, 4'd1, enc(2'b00, OP_SUB, 1'b1, 1000, 1'b0, 0));
        wr(1, 4'd2, enc(2'b00, OP_SUB, 1'b1, 1000, 1'b0, 0));
        wr(1, 4'd3, enc(2'b00, OP_MOV, 1'b0, 1, 1'b0, 4));
        wr(1, 4'd4, enc(2'b00, OP_JMP, 1'b1, 4, 1'b0, 0));
        do_reset();
        step(4);
        check("sat_lo", int'(out_sig), -999);

        // MUL: 12 * -3
        clear_all();
        wr(1, 4'd0, enc(2'b00, OP_MOV, 1'b1, 12, 1'b0, 1));
        wr(1, 4'd1, enc(2'b00, OP_MUL, 1'b1, -3, 1'b0, 0));
        wr(1, 4'd2, enc(2'b00, OP_MOV, 1'b0, 1, 1'b0, 4));
        wr(1, 4'd3, enc(2'b00, OP_JMP, 1'b1, 3, 1'b0, 0));
        do_reset();
        step(3);
        check("mul", int'(out_sig), -36);

        // NOT twice (7 -> 0 -> 100), routed through dat
        clear_all();
        wr(1, 4'd0, enc(2'b00, OP_MOV, 1'b1, 7, 1'b0, 1));
        wr(1, 4'd1, enc(2'b00, OP_NOT, 1'b0, 0, 1'b0, 0));
        wr(1, 4'd2, enc(2'b00, OP_NOT, 1'b0, 0, 1'b0, 0));
        wr(1, 4'd3, enc(2'b00, OP_MOV, 1'b0, 1, 1'b0, 2));
        wr(1, 4'd4, enc(2'b00, OP_MOV, 1'b0, 2, 1'b0, 4));
        wr(1, 4'd5, enc(2'b00, OP_JMP, 1'b1, 5, 1'b0, 0));
        do_reset();
        step(5);
        check("not_dat", int'(out_sig), 100);

        // Conditionals
        run_cond("teq_eq", OP_TEQ, 5, 5, 1);
        run_cond("teq_ne", OP_TEQ, 5, 6, 2);
        // Reset mid-program keeps memory: rerun last program with input 5
        in_sig = 11'sd5;
        do_reset();
        check("rst_mid_out", int'(out_sig), 0);
        step(4);
        check("retained_out", int'(out_sig), 1);
        run_cond("tgt_eq", OP_TGT, 10, 10, 2);
        run_cond("tgt_gt", OP_TGT, 10, 11, 1);
        run_cond("tlt_lt", OP_TLT, 10, -3, 1);

        // Sleep: MOV 1,p1; SLP 2; MOV 0,p1; JMP 3
        clear_all();
        fill_pass(1);
        wr(0, 4'd0, enc(2'b00, OP_MOV, 1'b1, 1, 1'b0, 4));
        wr(0, 4'd1, enc(2'b00, OP_SLP, 1'b1, 2, 1'b0, 0));
        wr(0, 4'd2, enc(2'b00, OP_MOV, 1'b1, 0, 1'b0, 4));
        wr(0, 4'd3, enc(2'b00, OP_JMP, 1'b1, 3, 1'b0, 0));
        do_reset();
        step(1);
        big = 1'b1;
        step(1);
        big = 1'b0;
        check("slp_issue_pc", int'(dut.dut0.program_counter), 1);
        step(3);
        check("slp_wait_pc", int'(dut.dut0.program_counter), 1);
        check("slp_wait_out", int'(out_sig), 1);
        big = 1'b1;
        step(1);
        big = 1'b0;
        step(3);
        check("slp_one_pc", int'(dut.dut0.program_counter), 1);
        check("slp_one_out", int'(out_sig), 1);
        big = 1'b1;
        step(1);
        big = 1'b0;
        check("slp_wake_pc", int'(dut.dut0.program_counter), 2);
        step(1);
        check("slp_wake_out1", int'(out_sig), 1);
        step(1);
        check("slp_wake_out0", int'(out_sig), 0);

        // Non-positive SLP acts as NOP
        clear_all();
        wr(0, 4'd0, enc(2'b00, OP_SLP, 1'b1, 0, 1'b0, 0));
        wr(0, 4'd1, enc(2'b00, OP_SLP, 1'b1, -4, 1'b0, 0));
        do_reset();
        step(2);
        check("slp_nop_pc", int'(dut.dut0.program_counter), 2);

        // PC wrap and JMP at word 15
        clear_all();
        do_reset();
        step(15);
        check("wrap_pc15", int'(dut.dut0.program_counter), 15);
        step(1);
        check("wrap_pc0", int'(dut.dut0.program_counter), 0);
        wr(0, 4'd15, enc(2'b00, OP_JMP, 1'b1, 3, 1'b0, 0));
        do_reset();
        step(16);
        check("jmp15_pc", int'(dut.dut0.program_counter), 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
